reg_file_param: RTL

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file: two registered read ports, one write port, power-up clear sequencer.
// Define REG_FILE_BYPASS_EN for write-first read-during-write; default build is read-first.
module reg_file_param #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            re,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rd_valid,
    output logic            init_busy
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [AW:0]   NR_W     = (AW+1)'(NUM_REGS);

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [XLEN-1:0]   rd1_q, rd1_d;
    logic [XLEN-1:0]   rd2_q, rd2_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;

    logic [XLEN-1:0]   mem [0:NUM_REGS-1];

    // Register 0 and addresses past the end are hardwired zero, so they are never "ok".
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NR_W);
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = wa;
        wr_data    = wd;
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_RUN: begin
                wr_en = we && addr_ok(wa);
                if (re) begin
                    rd_valid_d = 1'b1;
                    rd1_d      = '0;
                    rd2_d      = '0;
                    if (addr_ok(ra1)) rd1_d = mem[ra1];
                    if (addr_ok(ra2)) rd2_d = mem[ra2];
`ifdef REG_FILE_BYPASS_EN
                    if (we && addr_ok(ra1) && (wa == ra1)) rd1_d = wd;
                    if (we && addr_ok(ra2) && (wa == ra2)) rd2_d = wd;
`endif
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            idx_q      <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage has no reset of its own; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd1       = rd1_q;
    assign rd2       = rd2_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = (state_q == S_INIT);

endmodule
